// File: rtl/ddr3_mem_test_if.sv
// Local user interface between ddr3_mem_test (master) and the DDR3 controller (slave).
interface ddr3_mem_test_if;
    logic        init_start;
    logic        init_done;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        cmd_rdy;
    logic [25:0] addr;
    logic [4:0]  cmd_burst_cnt;
    logic        ofly_burst_len;
    logic [63:0] write_data;
    logic [7:0]  data_mask;
    logic        datain_rdy;
    logic [63:0] read_data;
    logic        read_data_valid;

    modport master (
        output init_start, cmd, cmd_valid, addr, cmd_burst_cnt, ofly_burst_len,
               write_data, data_mask,
        input  init_done, cmd_rdy, datain_rdy, read_data, read_data_valid
    );

    modport slave (
        input  init_start, cmd, cmd_valid, addr, cmd_burst_cnt, ofly_burst_len,
               write_data, data_mask,
        output init_done, cmd_rdy, datain_rdy, read_data, read_data_valid
    );
endinterface

// File: rtl/ddr3_mem_test.sv
// Write / read-back pattern tester for the DDR3 local user interface, looping forever.
// Optional: define MEMTEST_STOP_ON_ERR_EN to halt after the first mismatching read beat.
module ddr3_mem_test #(
    parameter logic [25:0] START_ADDR  = 26'd0,
    parameter logic [25:0] END_ADDR    = 26'h0000FF8,
    parameter int unsigned BEATS       = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic            clk,
    input  logic            rst,
    ddr3_mem_test_if.master mem,
    output logic            busy,
    output logic            fail,
    output logic            timeout,
    output logic [15:0]     err_count,
    output logic [15:0]     pass_count
);
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    CMD_WRITE = 4'b0010;
    localparam logic [3:0]    CMD_READ  = 4'b0001;

    typedef enum logic [2:0] {
        IDLE, INIT, WR_CMD, WR_DATA, RD_CMD, RD_WAIT, HALT
    } state_t;

    state_t         state, state_n;
    logic [25:0]    addr_q, addr_n;
    logic [BW-1:0]  beat_q, beat_n;
    logic [TW-1:0]  tcnt_q, tcnt_n;
    logic [15:0]    err_n, pass_n;
    logic           fail_n, timeout_n;
    logic           init_start_q;
    logic           handshake;
    logic           active;
    logic           cmd_valid;
    logic [3:0]     cmd;
    logic [63:0]    write_data;
    logic [31:0]    d32;
    logic [63:0]    exp_data;

    // Pattern for the current (addr, beat); the pass count seeds the low byte.
    assign d32      = {5'b0, beat_q[0], addr_q} ^ {24'b0, pass_count[7:0]};
    assign exp_data = {~d32, d32};

    assign active = (state == WR_CMD) || (state == WR_DATA) ||
                    (state == RD_CMD) || (state == RD_WAIT);
    assign busy   = (state != IDLE) && (state != HALT);

    assign mem.init_start     = init_start_q;
    assign mem.cmd            = cmd;
    assign mem.cmd_valid      = cmd_valid;
    assign mem.addr           = addr_q;
    assign mem.cmd_burst_cnt  = 5'd1;
    assign mem.ofly_burst_len = 1'b0;
    assign mem.write_data     = write_data;
    assign mem.data_mask      = '0;

    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        beat_n     = beat_q;
        err_n      = err_count;
        pass_n     = pass_count;
        fail_n     = fail;
        timeout_n  = timeout;
        handshake  = 1'b0;
        cmd_valid  = 1'b0;
        cmd        = '0;
        write_data = '0;

        case (state)
            IDLE: state_n = INIT;
            INIT: begin
                if (mem.init_done) begin
                    addr_n  = START_ADDR;
                    state_n = WR_CMD;
                end
            end
            WR_CMD: begin
                cmd_valid = 1'b1;
                cmd       = CMD_WRITE;
                if (mem.cmd_rdy) begin
                    handshake = 1'b1;
                    beat_n    = '0;
                    state_n   = WR_DATA;
                end
            end
            WR_DATA: begin
                write_data = exp_data;
                if (mem.datain_rdy) begin
                    handshake = 1'b1;
                    beat_n    = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_n = '0;
                        if (addr_q == END_ADDR) begin
                            addr_n  = START_ADDR;
                            state_n = RD_CMD;
                        end else begin
                            addr_n  = addr_q + 26'd8;
                            state_n = WR_CMD;
                        end
                    end
                end
            end
            RD_CMD: begin
                cmd_valid = 1'b1;
                cmd       = CMD_READ;
                if (mem.cmd_rdy) begin
                    handshake = 1'b1;
                    beat_n    = '0;
                    state_n   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem.read_data_valid) begin
                    handshake = 1'b1;
                    beat_n    = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_n = '0;
                        if (addr_q == END_ADDR) begin
                            pass_n  = pass_count + 1'b1;
                            addr_n  = START_ADDR;
                            state_n = WR_CMD;
                        end else begin
                            addr_n  = addr_q + 26'd8;
                            state_n = RD_CMD;
                        end
                    end
                    if (mem.read_data != exp_data) begin
                        fail_n = 1'b1;
                        if (err_count != '1)
                            err_n = err_count + 1'b1;
`ifdef MEMTEST_STOP_ON_ERR_EN
                        // Freeze the sweep position and pass count where the error hit.
                        addr_n  = addr_q;
                        pass_n  = pass_count;
                        state_n = HALT;
`endif
                    end
                end
            end
            default: state_n = HALT;
        endcase

        // A handshake on the final allowed cycle still counts as progress.
        if (active && !handshake && (tcnt_q == TMO_LAST)) begin
            timeout_n = 1'b1;
            fail_n    = 1'b1;
            state_n   = HALT;
        end

        tcnt_n = (active && (state_n == state) && !handshake) ? tcnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            beat_q       <= '0;
            tcnt_q       <= '0;
            err_count    <= '0;
            pass_count   <= '0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            init_start_q <= 1'b0;
        end else begin
            state        <= state_n;
            addr_q       <= addr_n;
            beat_q       <= beat_n;
            tcnt_q       <= tcnt_n;
            err_count    <= err_n;
            pass_count   <= pass_n;
            fail         <= fail_n;
            timeout      <= timeout_n;
            init_start_q <= (state == IDLE);
        end
    end
endmodule

// File: doc/ddr3_mem_test.md
Name: ddr3_mem_test

Overview:
- Traffic generator and checker driving the ddr3_x16 local user interface of the DDR3 controller; sits directly upstream of the controller in the top level.
- After controller init, writes a deterministic address-derived pattern over an address window, reads it back and compares, then repeats indefinitely.
- Status outputs (pass count, error count, fail flag) are routed to GPIO for bring-up.

Parameters:
- START_ADDR, 26'd0, first local word address of the test window (multiple of 8).
- END_ADDR, 26'h0000FF8, last command address of the window (multiple of 8, >= START_ADDR).
- BEATS, 2, 64-bit data beats per command (BL8 on x16).
- TIMEOUT_CYC, 4096, cycles allowed for cmd_rdy, datain_rdy or read data before a timeout fail.

Ports:
- clk  in  1  controller sclk domain.
- rst  in  1  reset, asynchronous, active-high.
- init_start  out  1  one-cycle pulse requesting controller initialisation.
- init_done  in  1  controller initialisation complete, level.
- cmd  out  4  4'b0010 WRITE, 4'b0001 READ, otherwise 4'b0000.
- cmd_valid  out  1  command valid.
- cmd_rdy  in  1  controller accepts command this cycle.
- addr  out  26  command address.
- cmd_burst_cnt  out  5  constant 5'd1.
- ofly_burst_len  out  1  constant 0.
- write_data  out  64  write beat data.
- data_mask  out  8  constant 8'h00.
- datain_rdy  in  1  controller consumes write_data this cycle.
- read_data  in  64  read beat data.
- read_data_valid  in  1  read beat valid.
- busy  out  1  test running.
- fail  out  1  sticky error or timeout.
- timeout  out  1  sticky timeout indication.
- err_count  out  16  mismatching beats, saturating at 16'hFFFF.
- pass_count  out  16  completed write+read sweeps, wraps.

Behaviour:
- Reset values: every output 0, except cmd_burst_cnt=5'd1. State = IDLE.
- Pattern for command address A and beat b (b = 0..BEATS-1): d32 = {5'b0, b[0], A} ^ {24'b0, pass_count[7:0]}; data = {~d32, d32}.
- FSM states and transitions:
  - IDLE: on the first cycle after reset, pulse init_start for one cycle, then go to INIT.
  - INIT: wait for init_done=1, then go to WR_CMD with addr=START_ADDR.
  - WR_CMD: drive cmd_valid=1, cmd=WRITE, addr. cmd_valid and addr stay stable until the cycle cmd_rdy=1. On that cycle go to WR_DATA with beat=0.
  - WR_DATA: write_data always presents the beat's pattern. Beat advances on each cycle with datain_rdy=1. After beat BEATS-1 is accepted: if addr==END_ADDR go to RD_CMD with addr=START_ADDR; otherwise addr+=8 and go to WR_CMD.
  - RD_CMD: same handshake as WR_CMD with cmd=READ. On acceptance go to RD_WAIT with beat=0.
  - RD_WAIT: on each read_data_valid, compare read_data with the pattern for (addr, beat). On mismatch, err_count increments (saturating) and fail is set. After beat BEATS-1: if addr==END_ADDR then pass_count+1 and go to WR_CMD with addr=START_ADDR; otherwise addr+=8 and go to RD_CMD.
  - HALT: cmd_valid=0 and all counters frozen. Exit only via rst.
- cmd_valid deasserts the cycle after acceptance. Only one command is outstanding at a time; the next command is never issued before the current command's data phase completes.
- Timeout: a cycle counter clears on state entry and on each handshake event. If it reaches TIMEOUT_CYC in WR_CMD, WR_DATA, RD_CMD or RD_WAIT, set timeout=1 and fail=1 and go to HALT. No timeout applies in INIT.
- read_data_valid outside RD_WAIT is ignored and not counted.
- busy=1 in every state except IDLE and HALT.
- pass_count increments with the new pattern seed taking effect from the next write sweep. Wrap from 16'hFFFF to 0 is legal.
- If init_done drops mid-test, the block does not react; timeout covers a stalled controller.
- rst at any time returns to IDLE with all reset values, and another init_start pulse follows.

Optional Feature:
- MEMTEST_STOP_ON_ERR_EN defined: the first mismatching beat sets fail, increments err_count to 1 and goes to HALT after that beat; no further commands are issued.
- Not defined: mismatches are counted and the test continues looping; HALT is reachable only via timeout.

Test Plan:
- Reset, then init_done=1 at cycle 20 -> init_start high exactly one cycle after reset, first WRITE cmd_valid with addr=0 only after init_done.
- Ideal controller model, END_ADDR=26'h18 -> 4 writes at 0/8/10/18 with beat data d32 = 0x00000000, 0x04000000, 0x00000008, ...; 4 reads; pass_count=1, err_count=0, fail=0. Second sweep data XORed with 0x01.
- cmd_rdy held low for 10 cycles -> cmd_valid, cmd and addr stable throughout; exactly one acceptance.
- Model corrupts bit 3 of beat 1 at addr 8 -> err_count=1, fail=1. Without the macro, the sweep completes and pass_count increments. With MEMTEST_STOP_ON_ERR_EN, HALT with busy=0.
- Model never returns read data -> after TIMEOUT_CYC=4096 cycles, timeout=1, fail=1, busy=0, no further cmd_valid.
- Assert rst during WR_DATA -> all outputs reset immediately; a new init_start pulse and a fresh sweep from START_ADDR follow.
